// File: rtl/sobel3x3_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers and a shift window yield |Gx|+|Gy|
// for each interior pixel of a raster-order frame, plus the per-frame maximum magnitude.
module sobel3x3_stream #(
  parameter int PIX_W    = 8,
  parameter int IMG_COLS = 576,
  parameter int IMG_ROWS = 436,
  parameter int OUT_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [OUT_W-1:0] frame_max,
  output logic             max_valid
);

  localparam int CW = $clog2(IMG_COLS);
  localparam int RW = $clog2(IMG_ROWS);
  localparam int SW = PIX_W + 4;

  logic [PIX_W-1:0] lb0 [IMG_COLS];
  logic [PIX_W-1:0] lb1 [IMG_COLS];

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Only the two previous window columns are stored; the right column comes straight
  // from the line buffers and the incoming pixel.
  logic [PIX_W-1:0] z2, z3, z5, z6, z8, z9;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic accept, transfer, col_end, row_end, win_ok;
  logic signed [SW-1:0] gx, gy, ax, ay;
  logic [SW-1:0] mag;
  logic [OUT_W-1:0] run_max, mag_out, fmax_next;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'({4'b0000, p});
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;
  assign col_end  = (col == CW'(IMG_COLS - 1));
  assign row_end  = (row == RW'(IMG_ROWS - 1));
  assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
  assign lb0_rd   = lb0[col];
  assign lb1_rd   = lb1[col];

  // Gradients over the window as it will be after this beat's shift.
  always_comb begin
    gx = (ext(lb1_rd) + (ext(lb0_rd) <<< 1) + ext(in_data))
       - (ext(z2) + (ext(z5) <<< 1) + ext(z8));
    gy = (ext(z8) + (ext(z9) <<< 1) + ext(in_data))
       - (ext(z2) + (ext(z3) <<< 1) + ext(lb1_rd));
    ax = gx[SW-1] ? -gx : gx;
    ay = gy[SW-1] ? -gy : gy;
    mag = SW'(ax) + SW'(ay);
    mag_out = OUT_W'(mag);
    fmax_next = (out_data > run_max) ? out_data : run_max;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0_rd;
      lb0[col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      z2 <= '0; z3 <= '0; z5 <= '0; z6 <= '0; z8 <= '0; z9 <= '0;
    end else if (accept) begin
      z2 <= z3; z3 <= lb1_rd;
      z5 <= z6; z6 <= lb0_rd;
      z8 <= z9; z9 <= in_data;
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && win_ok) begin
      out_valid <= 1'b1;
      out_data  <= mag_out;
      out_last  <= row_end && col_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_max   <= '0;
      frame_max <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= 1'b0;
      if (transfer) begin
        if (out_last) begin
          frame_max <= fmax_next;
          max_valid <= 1'b1;
          run_max   <= '0;
        end else begin
          run_max <= fmax_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel3x3_stream.sv
// Bench for sobel3x3_stream: three frame geometries, a 2-D image model feeding an
// expected-value scoreboard, and stall/handshake checks on the output side.
module tb_sobel3x3_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] in_data = '0;
  int sel = 0;

  logic iv [3];
  logic ir [3];
  logic ov [3];
  logic ol [3];
  logic mv [3];
  logic [11:0] od [3];
  logic [11:0] fm [3];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) iv[i] = in_valid && (sel == i);
  end

  sobel3x3_stream #(.PIX_W(8), .IMG_COLS(4), .IMG_ROWS(3), .OUT_W(12)) u_a (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]),
    .frame_max(fm[0]), .max_valid(mv[0]));

  sobel3x3_stream #(.PIX_W(8), .IMG_COLS(3), .IMG_ROWS(3), .OUT_W(12)) u_b (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]),
    .frame_max(fm[1]), .max_valid(mv[1]));

  sobel3x3_stream #(.PIX_W(8), .IMG_COLS(4), .IMG_ROWS(4), .OUT_W(12)) u_c (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]),
    .frame_max(fm[2]), .max_valid(mv[2]));

  int n_tests = 0;
  int n_fail = 0;
  int n_out, n_last, n_maxv;
  int exp_d[$];
  int exp_l[$];
  int exp_m[$];
  int img [4][4];
  bit rand_rdy = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pix(input int kind, input int r, input int c);
    case (kind)
      1:       return (r == 0 && c == 0) ? 1 : 0;
      2:       return (c >= 2) ? 255 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sobel(input int r, input int c);
    int gx, gy;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    return iabs(gx) + iabs(gy);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input int p, input bit gaps);
    int k;
    bit acc;
    if (gaps) begin
      k = $urandom_range(0, 2);
      repeat (k) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data = 8'(p);
    k = 0;
    forever begin
      @(negedge clk);
      acc = ir[sel];
      @(posedge clk);
      #1;
      k++;
      if (acc) break;
      if (k > 1000) begin
        chk("in_accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int rows, input int cols,
                            input int limit, input bit gaps);
    int fmax = 0;
    int cnt = 0;
    int e;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (cnt == limit) return;
        img[r][c] = pix(kind, r, c);
        if (r >= 2 && c >= 2) begin
          e = sobel(r - 1, c - 1);
          exp_d.push_back(e);
          exp_l.push_back((r == rows - 1 && c == cols - 1) ? 1 : 0);
          if (e > fmax) fmax = e;
        end
        drive(img[r][c], gaps);
        cnt++;
      end
    end
    exp_m.push_back(fmax);
  endtask

  task automatic start_test(input int s);
    sel = s;
    do_reset();
    n_out = 0; n_last = 0; n_maxv = 0;
    exp_d.delete(); exp_l.delete(); exp_m.delete();
  endtask

  task automatic end_test(input string name, input int nexp_out, input int nexp_frames);
    int k = 0;
    while ((exp_d.size() != 0 || exp_m.size() != 0) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_n_out"}, n_out, nexp_out);
    chk({name, "_n_last"}, n_last, nexp_frames);
    chk({name, "_n_max_valid"}, n_maxv, nexp_frames);
    chk({name, "_left_in_queue"}, exp_d.size() + exp_m.size(), 0);
  endtask

  // Output-side monitor, sampled on the falling edge.
  initial begin
    bit held = 0;
    int held_d = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 0;
      end else begin
        if (held) begin
          chk("stall_valid_held", ov[sel], 1);
          chk("stall_data_held", od[sel], held_d);
        end
        if (ov[sel] && !out_ready) chk("in_ready_during_stall", ir[sel], 0);
        held = ov[sel] && !out_ready;
        held_d = od[sel];
        if (ov[sel] && out_ready) begin
          n_out++;
          if (ol[sel]) n_last++;
          if (exp_d.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            chk("out_data", od[sel], exp_d.pop_front());
            chk("out_last", ol[sel], exp_l.pop_front());
          end
        end
        if (mv[sel]) begin
          n_maxv++;
          if (exp_m.size() == 0) chk("unexpected_max_valid", 1, 0);
          else chk("frame_max", fm[sel], exp_m.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", ov[i], 0);
      chk("reset_out_data", od[i], 0);
      chk("reset_out_last", ol[i], 0);
      chk("reset_frame_max", fm[i], 0);
      chk("reset_max_valid", mv[i], 0);
      chk("reset_in_ready", ir[i], 1);
    end

    start_test(0);
    send_frame(0, 3, 4, 99, 0);
    end_test("t1_zero_3x4", 2, 1);

    start_test(1);
    send_frame(1, 3, 3, 99, 0);
    end_test("t2_corner_3x3", 1, 1);

    start_test(2);
    send_frame(2, 4, 4, 99, 0);
    end_test("t3_step_4x4", 4, 1);

    start_test(2);
    rand_rdy = 1;
    send_frame(2, 4, 4, 99, 1);
    end_test("t4_backpressure", 4, 1);
    rand_rdy = 0;
    out_ready = 1'b1;

    start_test(2);
    send_frame(2, 4, 4, 5, 0);
    @(posedge clk); #1;
    do_reset();
    chk("t5_out_valid_after_reset", ov[2], 0);
    send_frame(2, 4, 4, 99, 0);
    end_test("t5_mid_frame_reset", 4, 1);

    start_test(2);
    send_frame(2, 4, 4, 99, 0);
    send_frame(0, 4, 4, 99, 0);
    end_test("t6_back_to_back", 8, 2);
    chk("t6_final_frame_max", fm[2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
